sync_fifo_ctl: RTL and testbench

- Single-clock, parametrised FIFO; successor to the dual-clock ex_fifo for blocks where producer and consumer share one clock.
- Adds data-count output and programmable almost-full/almost-empty flags.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/sync_fifo_ctl_if.sv | 30 +++
 rtl/sync_fifo_ctl.sv | 109 ++++++++++
 tb/tb_sync_fifo_ctl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctl_if.sv
// Handshake bundle for sync_fifo_ctl: producer/consumer side (master) and FIFO side (slave).
interface sync_fifo_ctl_if #(
  parameter int unsigned FIFO_WIDTH_Bit = 16,
  parameter int unsigned FIFO_DEPTH_Bit = 4
);
  logic                      wr_en;
  logic [FIFO_WIDTH_Bit-1:0] wr_data;
  logic                      wr_full;
  logic                      almost_full;
  logic                      overflow;
  logic                      rd_en;
  logic [FIFO_WIDTH_Bit-1:0] rd_data;
  logic                      rd_valid;
  logic                      rd_empty;
  logic                      almost_empty;
  logic                      underflow;
  logic [FIFO_DEPTH_Bit:0]   data_count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, almost_full, overflow, rd_data, rd_valid,
           rd_empty, almost_empty, underflow, data_count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, almost_full, overflow, rd_data, rd_valid,
           rd_empty, almost_empty, underflow, data_count
  );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error
// flags, synchronous flush and selectable standard / first-word-fall-through read.
module sync_fifo_ctl #(
  parameter int unsigned FIFO_WIDTH_Bit = 16,
  parameter int unsigned FIFO_DEPTH_Bit = 4,
  parameter int unsigned AFULL_TH       = 14,
  parameter int unsigned AEMPTY_TH      = 2,
  parameter int unsigned FWFT           = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  sync_fifo_ctl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_Bit;
  localparam int unsigned AW    = FIFO_DEPTH_Bit;
  localparam int unsigned CW    = FIFO_DEPTH_Bit + 1;

  typedef logic [CW-1:0] ptr_t;

  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t AF_C = ptr_t'(AFULL_TH);
  localparam ptr_t AE_C = ptr_t'(AEMPTY_TH);

  if (AFULL_TH <= AEMPTY_TH) begin : g_bad_threshold
    $error("sync_fifo_ctl: AFULL_TH must be greater than AEMPTY_TH");
  end

  logic [FIFO_WIDTH_Bit-1:0] mem [DEPTH];

  ptr_t                      wr_ptr, rd_ptr, count;
  ptr_t                      wr_ptr_n, rd_ptr_n, count_n;
  logic                      full, empty, afull, aempty;
  logic                      ovf, unf, rvalid;
  logic                      wr_acc, rd_acc;
  logic [FIFO_WIDTH_Bit-1:0] rdata;

  // Acceptance uses the flags registered at the start of the cycle.
  always_comb begin
    wr_acc   = bus.wr_en && !full;
    rd_acc   = bus.rd_en && !empty;
    wr_ptr_n = wr_acc ? wr_ptr + ONE : wr_ptr;
    rd_ptr_n = rd_acc ? rd_ptr + ONE : rd_ptr;
    count_n  = count;
    if (wr_acc && !rd_acc) begin
      count_n = count + ONE;
    end else if (!wr_acc && rd_acc) begin
      count_n = count - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (wr_ptr_n[CW-1] != rd_ptr_n[CW-1]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
      afull  <= (count_n >= AF_C);
      aempty <= (count_n <= AE_C);
      if (bus.wr_en && full) ovf <= 1'b1;
      if (bus.rd_en && empty) unf <= 1'b1;
      rvalid <= rd_acc;
      if (rd_acc) rdata <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Storage is not reset; gating on rst_n keeps a write off the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  // In FWFT mode rdata keeps the last popped word, shown while the FIFO is empty.
  assign bus.rd_data      = ((FWFT != 0) && !empty) ? mem[rd_ptr[AW-1:0]] : rdata;
  assign bus.rd_valid     = (FWFT != 0) ? !empty : rvalid;
  assign bus.wr_full      = full;
  assign bus.rd_empty     = empty;
  assign bus.almost_full  = afull;
  assign bus.almost_empty = aempty;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
  assign bus.data_count   = count;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives a standard-mode and an FWFT-mode sync_fifo_ctl with identical stimulus and
// checks both every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_ctl;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  sync_fifo_ctl_if #(.FIFO_WIDTH_Bit(16), .FIFO_DEPTH_Bit(4)) bs ();
  sync_fifo_ctl_if #(.FIFO_WIDTH_Bit(16), .FIFO_DEPTH_Bit(4)) bf ();

  sync_fifo_ctl #(.FIFO_WIDTH_Bit(16), .FIFO_DEPTH_Bit(4), .AFULL_TH(14),
                  .AEMPTY_TH(2), .FWFT(0))
    u_std (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bs.slave));

  sync_fifo_ctl #(.FIFO_WIDTH_Bit(16), .FIFO_DEPTH_Bit(4), .AFULL_TH(14),
                  .AEMPTY_TH(2), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bf.slave));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, plus sticky errors and the registered read.
  logic [15:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  bit          m_rv  = 1'b0;
  logic [15:0] m_rdq = '0;
  bit          wa, ra;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rdq = '0;
    end else if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      wa = bs.wr_en && (q.size() < DEPTH);
      ra = bs.rd_en && (q.size() > 0);
      if (bs.wr_en && !wa) m_ovf = 1'b1;
      if (bs.rd_en && !ra) m_unf = 1'b1;
      m_rv = ra;
      if (ra) m_rdq = q.pop_front();
      if (wa) q.push_back(bs.wr_data);
    end
  end

  int n;
  always @(negedge clk) begin
    n = q.size();
    chkv("std.data_count",  32'(bs.data_count), n);
    chk1("std.wr_full",      bs.wr_full,      n == DEPTH);
    chk1("std.rd_empty",     bs.rd_empty,     n == 0);
    chk1("std.almost_full",  bs.almost_full,  n >= 14);
    chk1("std.almost_empty", bs.almost_empty, n <= 2);
    chk1("std.overflow",     bs.overflow,     m_ovf);
    chk1("std.underflow",    bs.underflow,    m_unf);
    chk1("std.rd_valid",     bs.rd_valid,     m_rv);
    chkv("std.rd_data",      32'(bs.rd_data), 32'(m_rdq));
    chkv("fwft.data_count",  32'(bf.data_count), n);
    chk1("fwft.wr_full",     bf.wr_full,      n == DEPTH);
    chk1("fwft.rd_empty",    bf.rd_empty,     n == 0);
    chk1("fwft.almost_full", bf.almost_full,  n >= 14);
    chk1("fwft.almost_empty", bf.almost_empty, n <= 2);
    chk1("fwft.overflow",    bf.overflow,     m_ovf);
    chk1("fwft.underflow",   bf.underflow,    m_unf);
    chk1("fwft.rd_valid",    bf.rd_valid,     n != 0);
    if (n != 0) chkv("fwft.rd_data", 32'(bf.rd_data), 32'(q[0]));
  end

  task automatic drive(input bit w, input logic [15:0] d, input bit r, input bit c);
    bs.wr_en = w; bs.wr_data = d; bs.rd_en = r;
    bf.wr_en = w; bf.wr_data = d; bf.rd_en = r;
    clr = c;
    @(negedge clk);
  endtask

  int wbias;

  initial begin
    bs.wr_en = 1'b0; bs.wr_data = '0; bs.rd_en = 1'b0;
    bf.wr_en = 1'b0; bf.wr_data = '0; bf.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (5) drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk1("lit.reset_empty", bs.rd_empty, 1'b1);
    chk1("lit.reset_aempty", bs.almost_empty, 1'b1);
    chkv("lit.reset_count", 32'(bs.data_count), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 12) chk1("lit.afull_13", bs.almost_full, 1'b0);
      if (i == 13) chk1("lit.afull_14", bs.almost_full, 1'b1);
      if (i == 14) chk1("lit.full_15", bs.wr_full, 1'b0);
    end
    chkv("lit.count_full", 32'(bs.data_count), 32'd16);
    chk1("lit.wr_full", bs.wr_full, 1'b1);

    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chkv("lit.ovf_rd_data", 32'(bs.rd_data), 32'h0);
    chk1("lit.ovf_rd_valid", bs.rd_valid, 1'b1);
    chk1("lit.overflow", bs.overflow, 1'b1);
    chkv("lit.ovf_count", 32'(bs.data_count), 32'd15);

    for (int i = 0; i < 15; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chkv("lit.last_word", 32'(bs.rd_data), 32'd15);
    chk1("lit.drained_empty", bs.rd_empty, 1'b1);

    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    chk1("lit.underflow", bs.underflow, 1'b1);
    chkv("lit.unf_count", 32'(bs.data_count), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chkv("lit.unf_rd_data", 32'(bs.rd_data), 32'h1234);

    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk1("lit.fwft_not_empty", bf.rd_empty, 1'b0);
    chkv("lit.fwft_rd_data", 32'(bf.rd_data), 32'hA5A5);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk1("lit.fwft_popped", bf.rd_empty, 1'b1);

    for (int i = 0; i < 3; i++) drive(1'b1, 16'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 16'(200 + i), 1'b1, 1'b0);
    chkv("lit.wrap_count", 32'(bs.data_count), 32'd3);
    drive(1'b1, 16'hDEAD, 1'b1, 1'b1);
    chkv("lit.clr_count", 32'(bs.data_count), 32'd0);
    chk1("lit.clr_empty", bs.rd_empty, 1'b1);
    chk1("lit.clr_ovf", bs.overflow, 1'b0);
    chk1("lit.clr_unf", bs.underflow, 1'b0);

    for (int k = 0; k < 800; k++) begin
      wbias = ((k / 100) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 99) < wbias, 16'($urandom),
            $urandom_range(0, 99) >= wbias, $urandom_range(0, 63) == 0);
      if (k == 450) begin
        #2 rst_n = 1'b0;
        #1;
        chkv("lit.arst_count", 32'(bs.data_count), 32'd0);
        chk1("lit.arst_empty", bs.rd_empty, 1'b1);
        chk1("lit.arst_full", bs.wr_full, 1'b0);
        chk1("lit.arst_rd_valid", bs.rd_valid, 1'b0);
        chkv("lit.arst_rd_data", 32'(bs.rd_data), 32'h0);
        chk1("lit.arst_ovf", bs.overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
